fxp_div_ctrl: RTL and testbench

- Initiator-side controller for the Q(F) reciprocal engine. It computes quot = num / den as num × (1/den).
- Accepts signed Q(F) requests on a valid/ready interface and passes |den| to the engine through the start/done handshake.
- Multiplies |num| by the returned reciprocal, then applies sign and saturation.
- Sits between the watchdog datapath and the reciprocal engine. It is the only block that drives the engine's start/x_in.

---
 rtl/fxp_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_fxp_div_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fxp_div_ctrl.sv
// rtl/fxp_div_ctrl.sv - signed Q(F) divider: quot = num * (1/den) via the reciprocal engine
// Optional FXP_DIV_ROUND_EN: round the product magnitude half up instead of truncating.
module fxp_div_ctrl #(
  parameter int W       = 32,
  parameter int F       = 16,
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] num_in,
  input  logic [W-1:0] den_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] quot_out,
  output logic [1:0]   rsp_err,
  output logic         eng_start,
  output logic [W-1:0] eng_x,
  input  logic         eng_done,
  input  logic [W-1:0] eng_inv,
  input  logic         eng_invalid
);

  localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
  localparam int           CW   = $clog2(TIMEOUT + 1);
`ifdef FXP_DIV_ROUND_EN
  localparam logic [2*W-1:0] RND = (2*W)'(1) << (F - 1);
`endif

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MUL, SAT, RESP} state_t;

  state_t         state;
  logic           sign_r;
  logic [W-1:0]   num_mag_r;
  logic [W-1:0]   inv_r;
  logic [2*W-1:0] mag_r;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   num_abs;
  logic [W-1:0]   den_abs;
  logic [W-1:0]   den_sat;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] mag_next;
  logic           ovf;
  logic [W-1:0]   mag_sat;
  logic [W-1:0]   quot_next;

  always_comb begin
    num_abs = num_in[W-1] ? (~num_in + W'(1)) : num_in;
    den_abs = den_in[W-1] ? (~den_in + W'(1)) : den_in;
    // only den = -2^(W-1) has the top bit left after negation
    den_sat = den_abs[W-1] ? QMAX : den_abs;
    prod    = {{W{1'b0}}, num_mag_r} * {{W{1'b0}}, inv_r};
`ifdef FXP_DIV_ROUND_EN
    mag_next = (prod + RND) >> F;
`else
    mag_next = prod >> F;
`endif
    ovf       = |mag_r[2*W-1:W-1];
    mag_sat   = ovf ? QMAX : mag_r[W-1:0];
    quot_next = sign_r ? (~mag_sat + W'(1)) : mag_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      quot_out  <= '0;
      rsp_err   <= 2'd0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      num_mag_r <= '0;
      inv_r     <= '0;
      mag_r     <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            sign_r    <= num_in[W-1] ^ den_in[W-1];
            num_mag_r <= num_abs;
            if (den_in == '0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'd1;
              quot_out  <= num_in[W-1] ? (~QMAX + W'(1)) : QMAX;
            end else begin
              state     <= ISSUE;
              eng_start <= 1'b1;
              eng_x     <= den_sat;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (eng_done) begin
            inv_r <= eng_inv;
            if (eng_invalid) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'd3;
              quot_out  <= '0;
            end else begin
              state <= MUL;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'd3;
            quot_out  <= '0;
          end
        end
        MUL: begin
          mag_r <= mag_next;
          state <= SAT;
        end
        SAT: begin
          quot_out  <= quot_next;
          rsp_err   <= ovf ? 2'd2 : 2'd0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div_ctrl.sv
// tb/tb_fxp_div_ctrl.sv - randomized self-checking bench for fxp_div_ctrl with engine stub
// Reference model computes the quotient with plain 64-bit arithmetic.
module tb_fxp_div_ctrl;
  localparam int W       = 32;
  localparam int F       = 16;
  localparam int TIMEOUT = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] num_in = '0;
  logic [W-1:0] den_in = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] quot_out;
  logic [1:0]   rsp_err;
  logic         eng_start;
  logic [W-1:0] eng_x;
  logic         eng_done = 1'b0;
  logic [W-1:0] eng_inv = '0;
  logic         eng_invalid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  fxp_div_ctrl #(.W(W), .F(F), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .num_in(num_in), .den_in(den_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .quot_out(quot_out), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x),
    .eng_done(eng_done), .eng_inv(eng_inv), .eng_invalid(eng_invalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] recip(input logic [31:0] x);
    longint unsigned r;
    r = 64'h1_0000_0000 / {32'd0, x};
    if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_x(input logic [31:0] den);
    longint d;
    d = longint'($signed(den));
    if (d < 0) d = -d;
    if (d > 64'h7FFF_FFFF) d = 64'h7FFF_FFFF;
    return d[31:0];
  endfunction

  // lat == 0 means the engine never answers
  task automatic model(input logic [31:0] num, input logic [31:0] den, input logic [31:0] inv,
                       input int lat, input bit invalid,
                       output logic [31:0] q, output logic [1:0] e);
    longint n, d;
    longint unsigned nm, p, m;
    n = longint'($signed(num));
    d = longint'($signed(den));
    if (d == 0) begin
      e = 2'd1;
      q = (n >= 0) ? 32'h7FFF_FFFF : 32'h8000_0001;
    end else if (lat == 0 || invalid) begin
      e = 2'd3;
      q = 32'd0;
    end else begin
      nm = (n < 0) ? longint'(-n) : longint'(n);
      p  = nm * {32'd0, inv};
`ifdef FXP_DIV_ROUND_EN
      m = (p + (64'd1 << (F - 1))) >> F;
`else
      m = p >> F;
`endif
      e = 2'd0;
      if (m > 64'h7FFF_FFFF) begin
        m = 64'h7FFF_FFFF;
        e = 2'd2;
      end
      q = ((n < 0) != (d < 0)) ? 32'(-m) : m[31:0];
    end
  endtask

  task automatic do_txn(input string tag, input logic [31:0] num, input logic [31:0] den,
                        input logic [31:0] inv, input int lat, input bit invalid, input int hold);
    logic [31:0] q;
    logic [1:0]  e;
    int cyc, starts0, exp_lat;
    model(num, den, inv, lat, invalid, q, e);
    if (den == 0) exp_lat = 0;
    else if (lat == 0) exp_lat = TIMEOUT + 1;
    else if (invalid) exp_lat = lat + 1;
    else exp_lat = lat + 3;
    starts0 = start_cnt;
    req_valid = 1'b1; num_in = num; den_in = den;
    check({tag, "_req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    if (den != 0) begin
      check({tag, "_start"}, eng_start, 1);
      check({tag, "_x_start"}, eng_x, exp_x(den));
    end
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      eng_done = (lat != 0 && cyc == lat);
      if (eng_done) begin
        eng_inv = inv; eng_invalid = invalid;
        check({tag, "_x_done"}, eng_x, exp_x(den));
      end
    end
    eng_done = 1'b0; eng_invalid = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_starts"}, start_cnt - starts0, (den != 0) ? 1 : 0);
    check({tag, "_quot"}, quot_out, q);
    check({tag, "_err"}, rsp_err, e);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_quot"}, quot_out, q);
      check({tag, "_hold_err"}, rsp_err, e);
      check({tag, "_hold_req_ready"}, req_ready, 0);
    end
    // a request offered alongside rsp_ready must not be taken in RESP
    rsp_ready = 1'b1; req_valid = 1'b1; num_in = 32'h0001_0000; den_in = 32'h0001_0000;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check({tag, "_released"}, {rsp_valid, req_ready, eng_start}, 3'b010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] num, den, inv, x;
    int lat, hold;
    bit invalid, seen;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_x", eng_x, 0);
    check("rst_quot", quot_out, 0);
    check("rst_err", rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);

    do_txn("exact", 32'd196608, 32'd131072, 32'd32768, 3, 1'b0, 0);
    do_txn("neg_num", -32'sd196608, 32'd131072, 32'd32768, 2, 1'b0, 0);
    do_txn("neg_den", 32'd196608, -32'sd131072, 32'd32768, 5, 1'b0, 1);
    do_txn("div0_pos", 32'd65536, 32'd0, 32'd0, 1, 1'b0, 0);
    do_txn("div0_neg", -32'sd65536, 32'd0, 32'd0, 1, 1'b0, 2);
    do_txn("ovf", 32'h7FFF_0000, 32'd32768, 32'd131072, 4, 1'b0, 0);
    do_txn("timeout", 32'd65536, 32'd65536, 32'd65536, 0, 1'b0, 5);
    do_txn("invalid", 32'd65536, 32'd65536, 32'd65536, 4, 1'b1, 0);
    do_txn("min_den", 32'h8000_0000, 32'h8000_0000, 32'd2, 1, 1'b0, 0);
    do_txn("late_done", 32'd98304, 32'd196608, recip(32'd196608), TIMEOUT, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      num = $urandom;
      if ($urandom_range(0, 2) == 0) num = $signed(num) >>> $urandom_range(8, 24);
      case ($urandom_range(0, 15))
        0:       den = 32'd0;
        1:       den = 32'h8000_0000;
        2, 3, 4: den = $signed($urandom) >>> $urandom_range(8, 20);
        default: den = $urandom;
      endcase
      if (den == 0 && $urandom_range(0, 1) == 0) den = 32'd1;
      x = exp_x(den);
      inv = ($urandom_range(0, 4) == 0) ? $urandom : ((x != 0) ? recip(x) : 32'd0);
      lat = $urandom_range(1, TIMEOUT);
      invalid = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(0, 3);
      do_txn($sformatf("rand%0d", i), num, den, inv, lat, invalid, hold);
    end

    req_valid = 1'b1; num_in = 32'd65536; den_in = 32'd65536;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_eng_start", eng_start, 0);
    check("mid_rst_eng_x", eng_x, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    eng_done = 1'b1; eng_inv = 32'd65536;
    @(negedge clk);
    eng_done = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("late_done_ignored", seen, 0);
    check("post_rst_req_ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
